// File: rtl/usb_std_request_ext.sv
// Endpoint-0 chapter-9 request handler: decodes device/interface standard requests,
// streams descriptor/status bytes, and commits state changes after the status stage.
module usb_std_request_ext #(
    parameter int DESC_LEN = 36,
    parameter logic [8*DESC_LEN-1:0] DESC = {
        // config (9) + interface (9), bytes 35..18
        8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h04, 8'h09,
        8'h32, 8'hC0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h12, 8'h02, 8'h09,
        // device descriptor, bytes 17..0
        8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h56, 8'h78, 8'h12,
        8'h34, 8'h40, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h12
    },
    parameter int NUM_STRINGS = 0,
    parameter logic [16*((NUM_STRINGS == 0) ? 3 : NUM_STRINGS + 4)-1:0] DESC_OFFS =
        {16'd36, 16'd18, 16'd0},
    parameter int CONFIG_VALUE = 1,
    parameter int NUM_INTERFACES = 1,
    parameter int NUM_ALTS = 1,
    parameter bit SELF_POWERED = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3:0]                  ctl_xfer_endpoint,
    input  logic [7:0]                  ctl_xfer_type,
    input  logic [7:0]                  ctl_xfer_request,
    input  logic [15:0]                 ctl_xfer_value,
    input  logic [15:0]                 ctl_xfer_index,
    input  logic [15:0]                 ctl_xfer_length,
    input  logic                        ctl_xfer_req_i,
    output logic                        ctl_xfer_gnt_o,
    output logic                        ctl_xfer_stall_o,
    output logic                        ctl_tvalid_o,
    input  logic                        ctl_tready_i,
    output logic                        ctl_tlast_o,
    output logic [7:0]                  ctl_tdata_o,
    output logic [6:0]                  device_address,
    output logic [7:0]                  current_configuration,
    output logic                        configured,
    output logic [4*NUM_INTERFACES-1:0] alt_setting_o,
    output logic                        remote_wakeup_o,
    output logic                        standard_request
);

    localparam int NUM_OFFS = (NUM_STRINGS == 0) ? 3 : NUM_STRINGS + 4;

    localparam logic [7:0] REQ_GET_STATUS     = 8'd0;
    localparam logic [7:0] REQ_CLEAR_FEATURE  = 8'd1;
    localparam logic [7:0] REQ_SET_FEATURE    = 8'd3;
    localparam logic [7:0] REQ_SET_ADDRESS    = 8'd5;
    localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'd6;
    localparam logic [7:0] REQ_GET_CONFIG     = 8'd8;
    localparam logic [7:0] REQ_SET_CONFIG     = 8'd9;
    localparam logic [7:0] REQ_GET_INTERFACE  = 8'd10;
    localparam logic [7:0] REQ_SET_INTERFACE  = 8'd11;

    typedef enum logic [1:0] {IDLE, DATA_IN, WAIT_END} state_t;
    typedef enum logic [2:0] {SRC_DESC, SRC_DEV_STATUS, SRC_ZERO, SRC_CONFIG, SRC_ALT} src_t;
    typedef enum logic [2:0] {CMT_NONE, CMT_ADDR, CMT_CONFIG, CMT_IFACE,
                              CMT_SET_WAKE, CMT_CLR_WAKE} commit_t;

    state_t  r_state, w_state_nxt;
    logic    r_req_d;
    logic    r_gnt, r_stall;
    src_t    r_src;
    logic [15:0] r_base, r_last, r_count, r_idx;
    commit_t r_commit;
    logic [7:0]  r_arg;
    logic [7:0]  r_tdata;
    logic [6:0]  r_address;
    logic [7:0]  r_config;
    logic [NUM_INTERFACES-1:0][3:0] r_alt;
    logic    r_remote_wakeup;

    logic        w_std, w_req_rise, w_accept, w_beat, w_last;
    logic        w_is_get, w_iface_ok, w_desc_ok;
    logic [4:0]  w_rcpt;
    logic [15:0] w_desc_k;
    logic        w_dec_stall, w_dec_data;
    src_t        w_dec_src;
    commit_t     w_dec_commit;
    logic [15:0] w_dec_base, w_dec_src_len, w_dec_len;
    src_t        w_sel_src;
    logic [15:0] w_sel_base, w_sel_idx, w_sel_iface, w_fetch_addr;
    logic [7:0]  w_fetch_byte;

    assign w_std      = (ctl_xfer_endpoint == 4'd0) && (ctl_xfer_type[6:5] == 2'b00);
    assign w_req_rise = ctl_xfer_req_i && !r_req_d;
    assign w_accept   = (r_state == IDLE) && w_req_rise && w_std;
    assign w_beat     = (r_state == DATA_IN) && ctl_tready_i;
    assign w_last     = (r_count == r_last);
    assign w_is_get   = ctl_xfer_type[7];
    assign w_rcpt     = ctl_xfer_type[4:0];
    assign w_iface_ok = ctl_xfer_index < 16'(NUM_INTERFACES);

    // Request decode: every standard request stalls unless a case below accepts it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_desc_ok     = 1'b0;
        w_desc_k      = 16'd0;
        w_dec_stall   = w_std;
        w_dec_data    = 1'b0;
        w_dec_src     = SRC_ZERO;
        w_dec_commit  = CMT_NONE;
        w_dec_base    = 16'd0;
        w_dec_src_len = 16'd0;

        case (ctl_xfer_value[15:8])
            8'd1: begin w_desc_k = 16'd0; w_desc_ok = 1'b1; end
            8'd2: begin w_desc_k = 16'd1; w_desc_ok = 1'b1; end
            8'd3: if (NUM_STRINGS != 0 &&
                      {8'h00, ctl_xfer_value[7:0]} <= 16'(NUM_STRINGS)) begin
                w_desc_k  = 16'd2 + {8'h00, ctl_xfer_value[7:0]};
                w_desc_ok = 1'b1;
            end
            default: ;
        endcase

        case (ctl_xfer_request)
            REQ_GET_STATUS:
                if (w_is_get && w_rcpt == 5'd0) begin
                    w_dec_stall = 1'b0; w_dec_data = 1'b1;
                    w_dec_src = SRC_DEV_STATUS; w_dec_src_len = 16'd2;
                end else if (w_is_get && w_rcpt == 5'd1 && w_iface_ok) begin
                    w_dec_stall = 1'b0; w_dec_data = 1'b1;
                    w_dec_src = SRC_ZERO; w_dec_src_len = 16'd2;
                end
            REQ_CLEAR_FEATURE, REQ_SET_FEATURE:
                if (!w_is_get && w_rcpt == 5'd0 && ctl_xfer_value == 16'd1) begin
                    w_dec_stall  = 1'b0;
                    w_dec_commit = (ctl_xfer_request == REQ_SET_FEATURE) ? CMT_SET_WAKE
                                                                         : CMT_CLR_WAKE;
                end
            REQ_SET_ADDRESS:
                if (!w_is_get && w_rcpt == 5'd0 && ctl_xfer_value < 16'd128) begin
                    w_dec_stall = 1'b0; w_dec_commit = CMT_ADDR;
                end
            REQ_GET_DESCRIPTOR:
                if (w_is_get && w_rcpt == 5'd0 && w_desc_ok) begin
                    w_dec_stall = 1'b0; w_dec_data = 1'b1; w_dec_src = SRC_DESC;
                    for (int k = 0; k < NUM_OFFS - 1; k++) begin
                        if (w_desc_k == 16'(k)) begin
                            w_dec_base    = DESC_OFFS[16*k +: 16];
                            w_dec_src_len = DESC_OFFS[16*(k+1) +: 16] - DESC_OFFS[16*k +: 16];
                        end
                    end
                end
            REQ_GET_CONFIG:
                if (w_is_get && w_rcpt == 5'd0) begin
                    w_dec_stall = 1'b0; w_dec_data = 1'b1;
                    w_dec_src = SRC_CONFIG; w_dec_src_len = 16'd1;
                end
            REQ_SET_CONFIG:
                if (!w_is_get && w_rcpt == 5'd0 &&
                    (ctl_xfer_value == 16'd0 || ctl_xfer_value == 16'(CONFIG_VALUE))) begin
                    w_dec_stall = 1'b0; w_dec_commit = CMT_CONFIG;
                end
            REQ_GET_INTERFACE:
                if (w_is_get && w_rcpt == 5'd1 && w_iface_ok && configured) begin
                    w_dec_stall = 1'b0; w_dec_data = 1'b1;
                    w_dec_src = SRC_ALT; w_dec_src_len = 16'd1;
                end
            REQ_SET_INTERFACE:
                if (!w_is_get && w_rcpt == 5'd1 && w_iface_ok && configured &&
                    ctl_xfer_value < 16'(NUM_ALTS)) begin
                    w_dec_stall = 1'b0; w_dec_commit = CMT_IFACE;
                end
            default: ;
        endcase

        w_dec_len = (w_dec_src_len < ctl_xfer_length) ? w_dec_src_len : ctl_xfer_length;
    end

    // Byte fetch: byte 0 comes from the live decode at accept, later bytes from the latched request.
    always_comb begin
        w_sel_src    = (r_state == IDLE) ? w_dec_src      : r_src;
        w_sel_base   = (r_state == IDLE) ? w_dec_base     : r_base;
        w_sel_iface  = (r_state == IDLE) ? ctl_xfer_index : r_idx;
        w_sel_idx    = (r_state == IDLE) ? 16'd0          : r_count + 16'd1;
        w_fetch_addr = w_sel_base + w_sel_idx;
        w_fetch_byte = 8'h00;
        case (w_sel_src)
            SRC_DESC:
                for (int b = 0; b < DESC_LEN; b++)
                    if (w_fetch_addr == 16'(b)) w_fetch_byte = DESC[8*b +: 8];
            SRC_DEV_STATUS:
                if (w_sel_idx == 16'd0) w_fetch_byte = {6'b0, r_remote_wakeup, SELF_POWERED};
            SRC_CONFIG:
                w_fetch_byte = r_config;
            SRC_ALT:
                for (int i = 0; i < NUM_INTERFACES; i++)
                    if (w_sel_iface == 16'(i)) w_fetch_byte = {4'b0, r_alt[i]};
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:
                if (w_accept)
                    w_state_nxt = (w_dec_data && w_dec_len != 16'd0) ? DATA_IN : WAIT_END;
            DATA_IN:
                if (!ctl_xfer_req_i)      w_state_nxt = IDLE;
                else if (w_beat && w_last) w_state_nxt = WAIT_END;
            WAIT_END:
                if (!ctl_xfer_req_i)      w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
            r_req_d         <= 1'b0;
            r_gnt           <= 1'b0;
            r_stall         <= 1'b0;
            r_src           <= SRC_ZERO;
            r_base          <= 16'd0;
            r_last          <= 16'd0;
            r_count         <= 16'd0;
            r_idx           <= 16'd0;
            r_commit        <= CMT_NONE;
            r_arg           <= 8'd0;
            r_tdata         <= 8'd0;
            r_address       <= 7'd0;
            r_config        <= 8'd0;
            r_alt           <= '0;
            r_remote_wakeup <= 1'b0;
        end else begin
            r_req_d <= ctl_xfer_req_i;
            if (w_accept) begin
                r_gnt    <= !w_dec_stall;
                r_stall  <= w_dec_stall;
                r_src    <= w_dec_src;
                r_base   <= w_dec_base;
                r_last   <= w_dec_len - 16'd1;
                r_count  <= 16'd0;
                r_idx    <= ctl_xfer_index;
                r_arg    <= ctl_xfer_value[7:0];
                r_commit <= w_dec_stall ? CMT_NONE : w_dec_commit;
                r_tdata  <= w_fetch_byte;
            end else if (!ctl_xfer_req_i) begin
                r_gnt    <= 1'b0;
                r_stall  <= 1'b0;
                r_commit <= CMT_NONE;
                // Status stage finished: only a request that reached WAIT_END takes effect.
                if (r_state == WAIT_END) begin
                    case (r_commit)
                        CMT_ADDR:     r_address <= r_arg[6:0];
                        CMT_CONFIG: begin
                            r_config <= r_arg;
                            r_alt    <= '0;
                        end
                        CMT_IFACE:
                            for (int i = 0; i < NUM_INTERFACES; i++)
                                if (r_idx == 16'(i)) r_alt[i] <= r_arg[3:0];
                        CMT_SET_WAKE: r_remote_wakeup <= 1'b1;
                        CMT_CLR_WAKE: r_remote_wakeup <= 1'b0;
                        default: ;
                    endcase
                end
            end else if (w_beat && !w_last) begin
                r_count <= r_count + 16'd1;
                r_tdata <= w_fetch_byte;
            end
        end
    end

    assign ctl_xfer_gnt_o        = r_gnt;
    assign ctl_xfer_stall_o      = r_stall;
    assign ctl_tvalid_o          = (r_state == DATA_IN);
    assign ctl_tlast_o           = (r_state == DATA_IN) && w_last;
    assign ctl_tdata_o           = r_tdata;
    assign device_address        = r_address;
    assign current_configuration = r_config;
    assign configured            = (r_config != 8'd0);
    assign alt_setting_o         = r_alt;
    assign remote_wakeup_o       = r_remote_wakeup;
    assign standard_request      = w_std;

endmodule
